// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants for the instruction fetch stage
package ifetch_unit_pkg;

    localparam int unsigned ADDR_W_DEFAULT = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    localparam logic [0:0] ST_REQ  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    localparam int unsigned OP_HI    = 31;
    localparam int unsigned OP_LO    = 26;
    localparam int unsigned FUNCT_HI = 5;
    localparam int unsigned FUNCT_LO = 0;
    localparam int unsigned IMM_HI   = 15;
    localparam int unsigned IMM_LO   = 0;
    localparam int unsigned JIDX_HI  = 25;
    localparam int unsigned JIDX_LO  = 0;

    // Branch displacement is a signed word count relative to pc+4.
    function automatic logic [31:0] branch_offset(input logic [31:0] instr);
        logic [15:0] imm;
        imm = instr[IMM_HI:IMM_LO];
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// rtl/ifetch_unit_if.sv - instruction memory req/ack bus
interface ifetch_unit_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );

endinterface

// File: rtl/ifetch_unit_npc_calc.sv
// rtl/ifetch_unit_npc_calc.sv - next-PC selection: jump, taken branch or sequential
module npc_calc
    import ifetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    input  logic        branch_taken_i,
    input  logic        jump_i,
    output logic [31:0] npc_o
);

    logic [31:0] pc4;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        unused_op;

    assign pc4           = pc_i + 32'd4;
    assign jump_target   = {pc4[31:28], instr_i[JIDX_HI:JIDX_LO], 2'b00};
    assign branch_target = pc4 + branch_offset(instr_i);
    assign unused_op     = ^instr_i[OP_HI:OP_LO];

    always_comb begin
        npc_o = pc4;
        if (jump_i) begin
            npc_o = jump_target;
        end else if (branch_taken_i) begin
            npc_o = branch_target;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - fetch stage: holds PC, fetches one word per instruction
// over req/ack, and presents the registered word to the decoder.
module ifetch_unit
    import ifetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned ADDR_W   = ADDR_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    ifetch_unit_if.master     imem,
    input  logic              ex_done,
    input  logic              branch_taken,
    input  logic              jump,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic              instr_valid
);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              valid_q, valid_d;
    logic [ADDR_W-1:0] npc;

    npc_calc u_npc_calc (
        .pc_i           (pc_q),
        .instr_i        (instr_q),
        .branch_taken_i (branch_taken),
        .jump_i         (jump),
        .npc_o          (npc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        case (state_q)
            ST_REQ: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // instr is left as-is so the decoder sees a stable word until the next ack.
                if (ex_done) begin
                    pc_d    = npc;
                    valid_d = 1'b0;
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_REQ;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Reset parks the FSM in REQ, so the request must be masked while rst is held.
    assign imem.imem_req  = (state_q == ST_REQ) && !rst;
    assign imem.imem_addr = pc_q;

    assign pc          = pc_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign opcode      = instr_q[OP_HI:OP_LO];
    assign funct       = instr_q[FUNCT_HI:FUNCT_LO];

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - directed self-checking bench for ifetch_unit
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_done;
    logic        branch_taken;
    logic        jump;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        instr_valid;

    int checks = 0;
    int errors = 0;

    ifetch_unit_if imem_bus ();

    ifetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus.master),
        .ex_done      (ex_done),
        .branch_taken (branch_taken),
        .jump         (jump),
        .pc           (pc),
        .instr        (instr),
        .opcode       (opcode),
        .funct        (funct),
        .instr_valid  (instr_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds ack low for 'waits' REQ cycles (with hold-only controls toggled), then acks.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data, input int waits);
        for (int w = 0; w < waits; w++) begin
            chk("wait_req", imem_bus.imem_req, 1'b1);
            chk("wait_addr", imem_bus.imem_addr, addr);
            chk("wait_valid", instr_valid, 1'b0);
            ex_done = 1'b1; jump = 1'b1; branch_taken = 1'b1;
            tick();
            ex_done = 1'b0; jump = 1'b0; branch_taken = 1'b0;
        end
        chk("req", imem_bus.imem_req, 1'b1);
        chk("addr", imem_bus.imem_addr, addr);
        chk("valid_pre", instr_valid, 1'b0);
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = data;
        tick();
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        chk("valid_post", instr_valid, 1'b1);
        chk("instr", instr, data);
        chk("hold_req", imem_bus.imem_req, 1'b0);
    endtask

    task automatic execute(input logic br, input logic jmp, input logic [31:0] next_addr);
        ex_done = 1'b1; branch_taken = br; jump = jmp;
        tick();
        ex_done = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        chk("next_req", imem_bus.imem_req, 1'b1);
        chk("next_addr", imem_bus.imem_addr, next_addr);
        chk("next_valid", instr_valid, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        ex_done = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        imem_bus.imem_ack   = 1'b1;
        imem_bus.imem_rdata = 32'h1234_5678;
        #12;
        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_req", imem_bus.imem_req, 1'b0);
        chk("rst_instr", instr, 32'h0);
        imem_bus.imem_ack = 1'b0;
        #1 rst = 1'b0;
        #1;
        chk("rel_req", imem_bus.imem_req, 1'b1);
        chk("rel_addr", imem_bus.imem_addr, 32'h0000_3000);
        tick();

        // wait states: 3 stalled REQ cycles, then ack in the 4th
        fetch(32'h0000_3000, 32'h2008_0005, 3);
        chk("opcode", opcode, 6'h08);
        chk("funct", funct, 6'h05);

        // ack while in HOLD must not disturb the held word
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        tick();
        imem_bus.imem_ack = 1'b0;
        chk("hold_instr", instr, 32'h2008_0005);
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_pc", pc, 32'h0000_3000);

        execute(1'b0, 1'b0, 32'h0000_3004);
        chk("instr_kept", instr, 32'h2008_0005);

        fetch(32'h0000_3004, 32'h2008_0005, 0);
        execute(1'b0, 1'b0, 32'h0000_3008);
        fetch(32'h0000_3008, 32'h1000_FFFE, 0);
        execute(1'b1, 1'b0, 32'h0000_3004);
        fetch(32'h0000_3004, 32'h0000_0000, 0);
        execute(1'b0, 1'b0, 32'h0000_3008);
        fetch(32'h0000_3008, 32'h1000_FFFE, 0);
        execute(1'b0, 1'b0, 32'h0000_300C);
        fetch(32'h0000_300C, 32'h0000_0000, 0);
        execute(1'b0, 1'b0, 32'h0000_3010);

        // jump wins over branch (branch would give 0x0000_6014)
        fetch(32'h0000_3010, 32'h0800_0C00, 0);
        execute(1'b1, 1'b1, 32'h0000_3000);

        // backward branch to the top word: 0x3004 - 0x3008
        fetch(32'h0000_3000, 32'h1000_F3FE, 1);
        execute(1'b1, 1'b0, 32'hFFFF_FFFC);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        fetch(32'hFFFF_FFFC, 32'h0000_0021, 0);
        execute(1'b0, 1'b0, 32'h0000_0000);

        // reset during a REQ wait; ack while in reset is dropped
        tick();
        chk("pre_rst_req", imem_bus.imem_req, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_req", imem_bus.imem_req, 1'b0);
        chk("mid_rst_pc", pc, 32'h0000_3000);
        chk("mid_rst_instr", instr, 32'h0);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'h1234_5678;
        tick();
        tick();
        chk("rst_ack_valid", instr_valid, 1'b0);
        chk("rst_ack_instr", instr, 32'h0);
        imem_bus.imem_ack = 1'b0;
        rst = 1'b0;
        #1;
        chk("restart_req", imem_bus.imem_req, 1'b1);
        chk("restart_addr", imem_bus.imem_addr, 32'h0000_3000);
        fetch(32'h0000_3000, 32'h0000_0020, 0);
        chk("restart_funct", funct, 6'h20);
        chk("restart_opcode", opcode, 6'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
